// File: rtl/ch0re_types.sv
// ch0re_types: shared arbiter state/owner enums and the fetch word-select helper.
package ch0re_types;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RSP} arb_state_e;
    typedef enum logic [1:0] {ARB_OWN_NONE, ARB_OWN_IF, ARB_OWN_MEM} arb_owner_e;

    function automatic logic [31:0] if_word(input logic hi, input logic [63:0] d);
        return hi ? d[63:32] : d[31:0];
    endfunction

endpackage

// File: rtl/ch0re_mem_arbiter_if.sv
// ch0re_mem_arbiter_if: IF, MEM and shared memory-port signals of the arbiter.
interface ch0re_mem_arbiter_if #(parameter int ADDR_W = 64);

    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [31:0]       o_if_rdata;
    logic              i_mem_req;
    logic              i_mem_we;
    logic [7:0]        i_mem_be;
    logic [ADDR_W-1:0] i_mem_addr;
    logic [63:0]       i_mem_wdata;
    logic              o_mem_gnt;
    logic              o_mem_rvalid;
    logic [63:0]       o_mem_rdata;
    logic              o_bus_req;
    logic              o_bus_we;
    logic [7:0]        o_bus_be;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [63:0]       o_bus_wdata;
    logic              i_bus_gnt;
    logic              i_bus_rvalid;
    logic [63:0]       i_bus_rdata;
    logic              o_pl_stall;

    modport slave (
        input  i_if_req, i_if_addr, i_mem_req, i_mem_we, i_mem_be, i_mem_addr, i_mem_wdata,
               i_bus_gnt, i_bus_rvalid, i_bus_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata, o_mem_gnt, o_mem_rvalid, o_mem_rdata,
               o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata, o_pl_stall
    );

    modport master (
        output i_if_req, i_if_addr, i_mem_req, i_mem_we, i_mem_be, i_mem_addr, i_mem_wdata,
               i_bus_gnt, i_bus_rvalid, i_bus_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata, o_mem_gnt, o_mem_rvalid, o_mem_rdata,
               o_bus_req, o_bus_we, o_bus_be, o_bus_addr, o_bus_wdata, o_pl_stall
    );

endinterface

// File: rtl/ch0re_sat_counter.sv
// ch0re_sat_counter: up-counter that saturates at MAX; clr wins over inc.
module ch0re_sat_counter #(
    parameter int             WIDTH = 4,
    parameter logic [WIDTH-1:0] MAX = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] o_cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr ? '0 : (inc && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;

    assign o_cnt = cnt_q;

endmodule

// File: rtl/ch0re_mem_arbiter.sv
// ch0re_mem_arbiter: single-outstanding IF/MEM arbiter onto one memory port, MEM-priority with IF starvation bound.
// Defining CH0RE_ARB_PERF_EN adds saturating grant/conflict performance counters.
module ch0re_mem_arbiter
    import ch0re_types::*;
#(
    parameter int ADDR_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ch0re_mem_arbiter_if.slave    bus_if
`ifdef CH0RE_ARB_PERF_EN
    ,
    output logic [31:0]           o_perf_if_gnt,
    output logic [31:0]           o_perf_mem_gnt,
    output logic [31:0]           o_perf_conflict
`endif
);

    arb_state_e        state_q, state_d;
    arb_owner_e        owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [7:0]        be_q, be_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [3:0]        starve;
    logic              any_req, if_win, if_gnt, mem_gnt, done, in_req;

    always_comb begin
        any_req = bus_if.i_if_req | bus_if.i_mem_req;
        if_win  = bus_if.i_if_req & (~bus_if.i_mem_req | starve == 4'(STARVE_LIMIT));
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        done    = 1'b0;
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            ARB_IDLE: if (any_req && !rst) begin
                if_gnt  = if_win;
                mem_gnt = ~if_win;
                state_d = ARB_REQ;
                owner_d = if_win ? ARB_OWN_IF : ARB_OWN_MEM;
                addr_d  = if_win ? bus_if.i_if_addr : bus_if.i_mem_addr;
                we_d    = ~if_win & bus_if.i_mem_we;
                be_d    = if_win ? '0 : bus_if.i_mem_be;
                wdata_d = if_win ? '0 : bus_if.i_mem_wdata;
            end
            // A response arriving with the bus grant completes the transaction at once
            ARB_REQ: if (bus_if.i_bus_gnt) begin
                done    = bus_if.i_bus_rvalid;
                state_d = bus_if.i_bus_rvalid ? ARB_IDLE : ARB_RSP;
            end
            ARB_RSP: if (bus_if.i_bus_rvalid) begin
                done    = 1'b1;
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
        if (done) owner_d = ARB_OWN_NONE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= ARB_OWN_NONE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end

    ch0re_sat_counter #(.WIDTH(4), .MAX(4'(STARVE_LIMIT))) u_starve (
        .clk(clk), .rst(rst), .clr(if_gnt), .inc(mem_gnt & bus_if.i_if_req), .o_cnt(starve)
    );

    assign in_req              = state_q == ARB_REQ;
    assign bus_if.o_if_gnt     = if_gnt;
    assign bus_if.o_mem_gnt    = mem_gnt;
    assign bus_if.o_bus_req    = in_req;
    assign bus_if.o_bus_we     = in_req & we_q;
    assign bus_if.o_bus_be     = in_req ? be_q : '0;
    assign bus_if.o_bus_addr   = in_req ? addr_q : '0;
    assign bus_if.o_bus_wdata  = in_req ? wdata_q : '0;
    assign bus_if.o_if_rvalid  = done & owner_q == ARB_OWN_IF;
    assign bus_if.o_mem_rvalid = done & owner_q == ARB_OWN_MEM;
    assign bus_if.o_if_rdata   = bus_if.o_if_rvalid ? if_word(addr_q[2], bus_if.i_bus_rdata) : '0;
    assign bus_if.o_mem_rdata  = (bus_if.o_mem_rvalid & ~we_q) ? bus_if.i_bus_rdata : '0;
    assign bus_if.o_pl_stall   = ~rst & ((any_req & ~(if_gnt | mem_gnt)) | state_q != ARB_IDLE);

`ifdef CH0RE_ARB_PERF_EN
    ch0re_sat_counter #(.WIDTH(32)) u_perf_if (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(if_gnt), .o_cnt(o_perf_if_gnt)
    );
    ch0re_sat_counter #(.WIDTH(32)) u_perf_mem (
        .clk(clk), .rst(rst), .clr(1'b0), .inc(mem_gnt), .o_cnt(o_perf_mem_gnt)
    );
    ch0re_sat_counter #(.WIDTH(32)) u_perf_cf (
        .clk(clk), .rst(rst), .clr(1'b0),
        .inc(~rst & state_q == ARB_IDLE & bus_if.i_if_req & bus_if.i_mem_req), .o_cnt(o_perf_conflict)
    );
`endif

endmodule

// File: tb/tb_ch0re_mem_arbiter.sv
// tb_ch0re_mem_arbiter: directed scenarios plus randomized traffic against a cycle-scheduled transaction model.
module tb_ch0re_mem_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ch0re_mem_arbiter_if #(.ADDR_W(64)) arb();

`ifdef CH0RE_ARB_PERF_EN
    logic [31:0] p_if, p_mem, p_cf;
`endif

    ch0re_mem_arbiter #(.ADDR_W(64), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk),
        .rst(rst),
        .bus_if(arb)
`ifdef CH0RE_ARB_PERF_EN
        ,
        .o_perf_if_gnt(p_if),
        .o_perf_mem_gnt(p_mem),
        .o_perf_conflict(p_cf)
`endif
    );

    int total = 0, bad = 0, c = 0;
    bit if_pend, mem_pend, mem_auto, noise, use_fix;
    int if_pct, mem_pct, fdg, fdr, starve, bus_cycles;
    logic [63:0] if_addr, mem_addr, mem_wdata, fix_data, last_rdata;
    logic mem_we;
    logic [7:0] mem_be;
    // Scheduled transaction: bus grant lands in cycle g_c, response in r_c
    bit have, t_if, t_we;
    int g_c, r_c;
    logic [63:0] t_addr, t_wdata, t_rdata;
    logic [7:0] t_be;
    int log_if[$], log_gc[$], log_rc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] r64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic int qat(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    task automatic post_if(input logic [63:0] a);
        if_pend = 1'b1;
        if_addr = a;
    endtask

    task automatic post_mem(input logic we, input logic [7:0] be, input logic [63:0] a, input logic [63:0] d);
        mem_pend  = 1'b1;
        mem_we    = we;
        mem_be    = be;
        mem_addr  = a;
        mem_wdata = d;
    endtask

    task automatic clear_log();
        log_if.delete();
        log_gc.delete();
        log_rc.delete();
    endtask

    task automatic cyc();
        bit busy, eg_if, eg_mem, ebr, erv;
        logic [63:0] a;
        if (!if_pend && $urandom_range(99) < if_pct) begin
            a = r64();
            a[1:0] = 2'b00;
            post_if(a);
        end
        if (!mem_pend && (mem_auto || $urandom_range(99) < mem_pct))
            post_mem(1'($urandom_range(1)), 8'($urandom()), r64(), r64());
        busy = have && c <= r_c;
        arb.i_if_req     = if_pend;
        arb.i_if_addr    = if_addr;
        arb.i_mem_req    = mem_pend;
        arb.i_mem_we     = mem_we;
        arb.i_mem_be     = mem_be;
        arb.i_mem_addr   = mem_addr;
        arb.i_mem_wdata  = mem_wdata;
        arb.i_bus_gnt    = busy && c == g_c;
        arb.i_bus_rvalid = busy && c == r_c;
        arb.i_bus_rdata  = arb.i_bus_rvalid ? t_rdata : r64();
        if (noise && (!busy || c < g_c) && $urandom_range(7) == 0) arb.i_bus_rvalid = 1'b1;
        #1;
        eg_if  = !busy && if_pend && (!mem_pend || starve == LIMIT);
        eg_mem = !busy && mem_pend && !eg_if;
        ebr    = busy && c <= g_c;
        erv    = busy && c == r_c;
        chk("if_gnt", 64'(arb.o_if_gnt), 64'(eg_if));
        chk("mem_gnt", 64'(arb.o_mem_gnt), 64'(eg_mem));
        chk("bus_req", 64'(arb.o_bus_req), 64'(ebr));
        if (ebr) begin
            bus_cycles++;
            chk("bus_addr", arb.o_bus_addr, t_addr);
            chk("bus_we", 64'(arb.o_bus_we), 64'(t_we));
            if (!t_if) begin
                chk("bus_be", 64'(arb.o_bus_be), 64'(t_be));
                chk("bus_wdata", arb.o_bus_wdata, t_wdata);
            end
        end
        chk("if_rvalid", 64'(arb.o_if_rvalid), 64'(erv && t_if));
        chk("mem_rvalid", 64'(arb.o_mem_rvalid), 64'(erv && !t_if));
        if (erv) begin
            log_rc.push_back(c);
            last_rdata = t_if ? 64'(arb.o_if_rdata) : arb.o_mem_rdata;
            chk(t_if ? "if_rdata" : "mem_rdata", last_rdata,
                t_if ? (t_addr[2] ? 64'(t_rdata[63:32]) : 64'(t_rdata[31:0])) : (t_we ? 64'h0 : t_rdata));
        end
        chk("stall", 64'(arb.o_pl_stall), 64'(((if_pend || mem_pend) && !(eg_if || eg_mem)) || busy));
        if (eg_if || eg_mem) begin
            log_if.push_back(int'(eg_if));
            log_gc.push_back(c);
            starve  = eg_if ? 0 : (if_pend && starve < LIMIT) ? starve + 1 : starve;
            have    = 1'b1;
            g_c     = c + 1 + (fdg >= 0 ? fdg : int'($urandom_range(3)));
            r_c     = g_c + (fdr >= 0 ? fdr : int'($urandom_range(2)));
            t_if    = eg_if;
            t_addr  = eg_if ? if_addr : mem_addr;
            t_we    = eg_mem && mem_we;
            t_be    = mem_be;
            t_wdata = mem_wdata;
            t_rdata = use_fix ? fix_data : r64();
            if (eg_if) if_pend = 1'b0;
            else       mem_pend = 1'b0;
        end
        @(negedge clk);
        c++;
    endtask

    task automatic drain();
        if_pct   = 0;
        mem_pct  = 0;
        mem_auto = 1'b0;
        for (int i = 0; i < 40 && ((have && c <= r_c) || if_pend || mem_pend); i++) cyc();
        chk("drain_idle", 64'((have && c <= r_c) || if_pend || mem_pend), 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_if_gnt", 64'(arb.o_if_gnt), 64'h0);
        chk("rst_mem_gnt", 64'(arb.o_mem_gnt), 64'h0);
        chk("rst_if_rvalid", 64'(arb.o_if_rvalid), 64'h0);
        chk("rst_mem_rvalid", 64'(arb.o_mem_rvalid), 64'h0);
        chk("rst_bus_req", 64'(arb.o_bus_req), 64'h0);
        chk("rst_bus_we", 64'(arb.o_bus_we), 64'h0);
        chk("rst_bus_be", 64'(arb.o_bus_be), 64'h0);
        chk("rst_bus_addr", arb.o_bus_addr, 64'h0);
        chk("rst_stall", 64'(arb.o_pl_stall), 64'h0);
`ifdef CH0RE_ARB_PERF_EN
        chk("rst_perf", {p_if, p_mem | p_cf}, 64'h0);
`endif
        have     = 1'b0;
        starve   = 0;
        if_pend  = 1'b0;
        mem_pend = 1'b0;
        @(negedge clk);
        arb.i_if_req     = 1'b0;
        arb.i_mem_req    = 1'b0;
        arb.i_bus_gnt    = 1'b0;
        arb.i_bus_rvalid = 1'b0;
        rst = 1'b0;
        c++;
    endtask

    initial begin
        fdg = -1;
        fdr = -1;
        arb.i_if_req     = 1'b1;
        arb.i_if_addr    = '0;
        arb.i_mem_req    = 1'b1;
        arb.i_mem_we     = 1'b0;
        arb.i_mem_be     = '0;
        arb.i_mem_addr   = '0;
        arb.i_mem_wdata  = '0;
        arb.i_bus_gnt    = 1'b0;
        arb.i_bus_rvalid = 1'b0;
        arb.i_bus_rdata  = '0;
        @(negedge clk);
        do_reset();

        // Fetch of the upper word: grant in N, data in N+2
        clear_log();
        use_fix  = 1'b1;
        fix_data = 64'h1111_2222_3333_4444;
        fdg = 0;
        fdr = 1;
        post_if(64'h104);
        repeat (4) cyc();
        chk("s1_latency", 64'(qat(log_rc, 0) - qat(log_gc, 0)), 64'd2);
        chk("s1_rdata", last_rdata, 64'h1111_2222);

        // Simultaneous requests: MEM first, IF in the cycle after MEM's response
        clear_log();
        use_fix = 1'b0;
        fdg = -1;
        fdr = -1;
        post_mem(1'b0, 8'hFF, 64'h2000, 64'h0);
        post_if(64'h300);
        for (int i = 0; i < 30 && log_rc.size() < 2; i++) cyc();
        chk("s2_first_mem", 64'(qat(log_if, 0)), 64'd0);
        chk("s2_second_if", 64'(qat(log_if, 1)), 64'd1);
        chk("s2_gap", 64'(qat(log_gc, 1) - qat(log_rc, 0)), 64'd1);

        // Store held on the bus three cycles before acceptance
        clear_log();
        use_fix    = 1'b1;
        fix_data   = 64'hCAFE_F00D_1234_5678;
        fdg        = 2;
        fdr        = 1;
        bus_cycles = 0;
        post_mem(1'b1, 8'h0F, 64'h4008, 64'hDEAD);
        repeat (6) cyc();
        chk("s4_bus_cycles", 64'(bus_cycles), 64'd3);
        chk("s4_responses", 64'(log_rc.size()), 64'd1);
        chk("s4_store_rdata", last_rdata, 64'h0);

        // Starvation bound: four MEM grants, forced IF grant, then MEM again
        do_reset();
        clear_log();
        use_fix  = 1'b0;
        fdg      = -1;
        fdr      = -1;
        mem_auto = 1'b1;
        post_if(64'h500);
        for (int i = 0; i < 80 && log_if.size() < 5; i++) cyc();
        for (int i = 0; i < 4; i++) chk("s3_mem_grant", 64'(qat(log_if, i)), 64'd0);
        chk("s3_if_grant", 64'(qat(log_if, 4)), 64'd1);
`ifdef CH0RE_ARB_PERF_EN
        chk("perf_mem_gnt", 64'(p_mem), 64'd4);
        chk("perf_if_gnt", 64'(p_if), 64'd1);
        chk("perf_conflict", 64'(p_cf), 64'd5);
`endif
        for (int i = 0; i < 30 && log_if.size() < 6; i++) cyc();
        chk("s3_mem_resume", 64'(qat(log_if, 5)), 64'd0);
        drain();

        // Reset while waiting for the response; a late response is dropped
        clear_log();
        fdg = 0;
        fdr = 3;
        post_if(64'h600);
        repeat (3) cyc();
        arb.i_if_req = 1'b1;
        do_reset();
        arb.i_bus_rvalid = 1'b1;
        arb.i_bus_rdata  = r64();
        #1;
        chk("s5_late_if_rvalid", 64'(arb.o_if_rvalid), 64'h0);
        chk("s5_late_mem_rvalid", 64'(arb.o_mem_rvalid), 64'h0);
        chk("s5_late_bus_req", 64'(arb.o_bus_req), 64'h0);
        @(negedge clk);
        c++;
        arb.i_bus_rvalid = 1'b0;

        // Random traffic with spurious responses
        fdg     = -1;
        fdr     = -1;
        noise   = 1'b1;
        if_pct  = 35;
        mem_pct = 35;
        repeat (500) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
